// File: rtl/nand_acc_sequencer_if.sv
// Bus bundle between the NAND accumulator sequencer and its environment:
// program-load port, run control, datapath drive and run status.
interface nand_acc_sequencer_if;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       start;
  logic       acc_in;
  logic       dp_d;
  logic       dp_load;
  logic       busy;
  logic       done;
  logic       result;
  logic       timeout;
  logic [3:0] pc;
  logic [7:0] step_count;

  // Environment side: loads the program, starts runs, returns the accumulator
  modport master (
    output prog_we, prog_addr, prog_data, start, acc_in,
    input  dp_d, dp_load, busy, done, result, timeout, pc, step_count
  );

  // Sequencer side
  modport slave (
    input  prog_we, prog_addr, prog_data, start, acc_in,
    output dp_d, dp_load, busy, done, result, timeout, pc, step_count
  );
endinterface

// File: rtl/nand_acc_sequencer.sv
// Tiny program sequencer driving a one-bit NAND accumulator datapath.
// Runs a 16-word program (LOAD / NAND / JNZ / HALT) from address 0, one
// instruction per cycle, bounded by MAX_STEPS executed instructions.
module nand_acc_sequencer #(
  parameter int MAX_STEPS = 255
) (
  input logic              clk,
  input logic              preset_n,
  nand_acc_sequencer_if.slave bus
);

  localparam logic [7:0] LP_MAX = 8'(MAX_STEPS);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_JNZ  = 2'b10;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t     r_state;
  logic [7:0] r_mem [16];
  logic [3:0] r_pc;
  logic [7:0] r_step;
  logic       r_done;
  logic       r_result;
  logic       r_timeout;

  logic [7:0] w_instr;
  logic [1:0] w_op;
  logic       w_b;
  logic [3:0] w_target;
  logic       w_limit;
  logic       w_dpLoad;
  logic       w_dpD;
  logic       w_unused;

  assign w_instr  = r_mem[r_pc];
  assign w_op     = w_instr[7:6];
  assign w_b      = w_instr[5];
  assign w_target = w_instr[3:0];
  assign w_unused = w_instr[4];
  assign w_limit  = (r_step >= LP_MAX);

  assign bus.dp_load    = w_dpLoad;
  assign bus.dp_d       = w_dpD;
  assign bus.busy       = (r_state == RUN);
  assign bus.done       = r_done;
  assign bus.result     = r_result;
  assign bus.timeout    = r_timeout;
  assign bus.pc         = r_pc;
  assign bus.step_count = r_step;

  // Program memory: writable only while idle, never cleared by reset
  always_ff @(posedge clk) begin
    if (bus.prog_we && (r_state == IDLE)) begin
      r_mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Datapath issue: hold the accumulator unless a LOAD or NAND executes now
  always_comb begin
    w_dpLoad = 1'b1;
    w_dpD    = bus.acc_in;
    if ((r_state == RUN) && !w_limit) begin
      if (w_op == OP_LOAD) begin
        w_dpD = w_b;
      end else if (w_op == OP_NAND) begin
        w_dpLoad = 1'b0;
        w_dpD    = w_b;
      end
    end
  end

  // Run control: start, per-cycle execution, HALT / step-limit termination
  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      r_state   <= IDLE;
      r_pc      <= 4'd0;
      r_step    <= 8'd0;
      r_done    <= 1'b0;
      r_result  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.start) begin
          r_state   <= RUN;
          r_pc      <= 4'd0;
          r_step    <= 8'd0;
          r_timeout <= 1'b0;
        end
      end else if (w_limit) begin
        r_state   <= IDLE;
        r_result  <= bus.acc_in;
        r_timeout <= 1'b1;
        r_done    <= 1'b1;
      end else if ((w_op == OP_LOAD) || (w_op == OP_NAND)) begin
        r_pc   <= r_pc + 4'd1;
        r_step <= r_step + 8'd1;
      end else if (w_op == OP_JNZ) begin
        r_pc   <= bus.acc_in ? w_target : (r_pc + 4'd1);
        r_step <= r_step + 8'd1;
      end else begin
        r_state  <= IDLE;
        r_result <= bus.acc_in;
        r_done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nand_acc_sequencer.sv
// Bench for nand_acc_sequencer: emulates the NAND accumulator datapath and
// compares every run cycle against an instruction-level program interpreter.
module tb_nand_acc_sequencer;

  localparam int TB_MAX = 8;

  logic clk = 1'b0;
  logic preset_n = 1'b0;
  logic acc = 1'b0;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] tbProg [16];

  nand_acc_sequencer_if bus();

  nand_acc_sequencer #(.MAX_STEPS(TB_MAX)) dut (
    .clk      (clk),
    .preset_n (preset_n),
    .bus      (bus)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  assign bus.acc_in = acc;

  // Accumulator datapath the sequencer controls
  always @(posedge clk) begin
    acc <= bus.dp_load ? bus.dp_d : ~(acc & bus.dp_d);
  end

  // Absolute run-time guard
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] ins(input logic [1:0] op, input logic b, input logic [3:0] t);
    return {op, b, 1'b0, t};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic writeProg(input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = data;
    tbProg[addr]  = data;
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  // Start a run and follow it cycle by cycle with an interpreter of the program
  task automatic applyStimulus(input string tag, input bit disturb,
                               input bit writeWithStart, input logic [7:0] startWord);
    int mPc;
    int mSteps;
    logic mAcc;
    bit ended;
    bit mTimeout;
    logic expLoad;
    logic expD;
    logic [7:0] w;
    @(negedge clk);
    bus.start = 1'b1;
    if (writeWithStart) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = 4'd0;
      bus.prog_data = startWord;
      tbProg[0]     = startWord;
    end
    mAcc = acc;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    mPc = 0;
    mSteps = 0;
    ended = 1'b0;
    mTimeout = 1'b0;
    for (int cyc = 0; cyc < 40 && !ended; cyc++) begin
      checkOutput({tag, " busy"}, bus.busy, 1);
      checkOutput({tag, " pc"}, bus.pc, mPc);
      checkOutput({tag, " step_count"}, bus.step_count, mSteps);
      checkOutput({tag, " done low in run"}, bus.done, 0);
      if (disturb && cyc == 1) begin
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd0;
        bus.prog_data = 8'hC0;
        bus.start     = 1'b1;
      end else begin
        bus.prog_we = 1'b0;
        bus.start   = 1'b0;
      end
      w = tbProg[mPc];
      if (mSteps == TB_MAX) begin
        expLoad = 1'b1;
        expD = mAcc;
        ended = 1'b1;
        mTimeout = 1'b1;
      end else begin
        case (w[7:6])
          2'd0: begin
            expLoad = 1'b1;
            expD = w[5];
            mAcc = w[5];
            mPc = (mPc + 1) % 16;
            mSteps++;
          end
          2'd1: begin
            expLoad = 1'b0;
            expD = w[5];
            mAcc = !(mAcc && w[5]);
            mPc = (mPc + 1) % 16;
            mSteps++;
          end
          2'd2: begin
            expLoad = 1'b1;
            expD = mAcc;
            mPc = mAcc ? int'(w[3:0]) : (mPc + 1) % 16;
            mSteps++;
          end
          default: begin
            expLoad = 1'b1;
            expD = mAcc;
            ended = 1'b1;
          end
        endcase
      end
      checkOutput({tag, " dp_load"}, bus.dp_load, expLoad);
      checkOutput({tag, " dp_d"}, bus.dp_d, expD);
      @(negedge clk);
    end
    bus.prog_we = 1'b0;
    bus.start   = 1'b0;
    checkOutput({tag, " run ended in budget"}, ended, 1);
    checkOutput({tag, " done pulse"}, bus.done, 1);
    checkOutput({tag, " busy after end"}, bus.busy, 0);
    checkOutput({tag, " result"}, bus.result, mAcc);
    checkOutput({tag, " timeout"}, bus.timeout, mTimeout);
    checkOutput({tag, " final step_count"}, bus.step_count, mSteps);
    @(negedge clk);
    checkOutput({tag, " done one cycle"}, bus.done, 0);
    checkOutput({tag, " result held"}, bus.result, mAcc);
    checkOutput({tag, " timeout held"}, bus.timeout, mTimeout);
  endtask

  // Directed scenarios followed by random programs
  initial begin
    bus.prog_we   = 1'b0;
    bus.prog_addr = 4'd0;
    bus.prog_data = 8'd0;
    bus.start     = 1'b0;
    for (int i = 0; i < 16; i++) tbProg[i] = 8'hC0;

    #12;
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset done", bus.done, 0);
    checkOutput("reset result", bus.result, 0);
    checkOutput("reset timeout", bus.timeout, 0);
    checkOutput("reset pc", bus.pc, 0);
    checkOutput("reset step_count", bus.step_count, 0);
    checkOutput("reset dp_load", bus.dp_load, 1);
    checkOutput("reset dp_d", bus.dp_d, acc);
    @(negedge clk);
    preset_n = 1'b1;
    for (int i = 0; i < 16; i++) writeProg(4'(i), 8'hC0);

    writeProg(4'd0, ins(2'd0, 1'b1, 4'd0));
    writeProg(4'd1, ins(2'd1, 1'b1, 4'd0));
    writeProg(4'd2, ins(2'd3, 1'b0, 4'd0));
    applyStimulus("load1_nand1", 1'b0, 1'b0, 8'd0);

    writeProg(4'd0, ins(2'd0, 1'b0, 4'd0));
    writeProg(4'd1, ins(2'd1, 1'b0, 4'd0));
    applyStimulus("load0_nand0", 1'b0, 1'b0, 8'd0);

    writeProg(4'd0, ins(2'd0, 1'b1, 4'd0));
    writeProg(4'd1, ins(2'd2, 1'b0, 4'd3));
    writeProg(4'd2, ins(2'd0, 1'b0, 4'd0));
    writeProg(4'd3, ins(2'd3, 1'b0, 4'd0));
    applyStimulus("jnz_taken", 1'b0, 1'b0, 8'd0);

    for (int i = 0; i < 6; i++) writeProg(4'(i), ins(2'd0, 1'b1, 4'd0));
    writeProg(4'd6, ins(2'd3, 1'b0, 4'd0));
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && bus.pc != 4'd5; i++) @(negedge clk);
    checkOutput("midrun reached pc5", bus.pc, 5);
    #2;
    preset_n = 1'b0;
    #1;
    checkOutput("midrun reset busy", bus.busy, 0);
    checkOutput("midrun reset pc", bus.pc, 0);
    checkOutput("midrun reset done", bus.done, 0);
    checkOutput("midrun reset result", bus.result, 0);
    checkOutput("midrun reset timeout", bus.timeout, 0);
    checkOutput("midrun reset dp_load", bus.dp_load, 1);
    @(negedge clk);
    preset_n = 1'b1;
    @(negedge clk);
    checkOutput("after reset no done", bus.done, 0);
    checkOutput("after reset idle", bus.busy, 0);
    applyStimulus("memory retained", 1'b0, 1'b0, 8'd0);

    writeProg(4'd0, ins(2'd0, 1'b1, 4'd0));
    writeProg(4'd1, ins(2'd2, 1'b0, 4'd1));
    applyStimulus("step limit", 1'b0, 1'b0, 8'd0);
    applyStimulus("run ignores we/start", 1'b1, 1'b0, 8'd0);
    applyStimulus("original word kept", 1'b0, 1'b0, 8'd0);
    applyStimulus("write with start", 1'b0, 1'b1, ins(2'd0, 1'b0, 4'd0));

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 16; i++) writeProg(4'(i), 8'($urandom));
      applyStimulus($sformatf("random%0d", r), 1'b0, 1'b0, 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
